// File: rtl/csram_pkg.sv
// Shared types and helpers for the RANC core CSRAM controller.
// Optional build macro used by the controller: CSRAM_PARITY_EN.
package csram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CLR,
        SRC_FW,
        SRC_HOST
    } src_e;

    // Upper bound on row width accepted by field_mask().
    localparam int MAX_ROW_W = 1024;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_ROW_W-1:0] field_mask(input int lsb, input int w);
        logic [MAX_ROW_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_ROW_W; i++) begin
            if (i >= lsb && i < lsb + w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csram_sdp_array.sv
// Simple dual-port row array: one bit-masked write and one registered
// read per cycle; a same-row read and write returns the old row.
module csram_sdp_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 368
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_wmask,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // NOTE: the storage array has no reset; only the read register is reset,
    // which keeps the array mappable onto SRAM macros or block RAM.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
    end

    // Read-first falls out of both processes sampling r_mem before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/csram_ctrl.sv
// CSRAM controller: read port, potential write-back, host row writes and a
// potential-field clear sweep. Build macro CSRAM_PARITY_EN adds row parity.
module csram_ctrl
    import csram_pkg::*;
#(
    parameter int                 NUM_NEURONS = 256,
    parameter int                 WIDTH       = 368,
    parameter int                 FIELD_LSB   = 103,
    parameter int                 FIELD_W     = 9,
    parameter logic [FIELD_W-1:0] CLR_VALUE   = '0,
    parameter int                 AUTO_CLEAR  = 1,
    localparam int                AW          = addr_w(NUM_NEURONS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    input  logic               fw_en,
    input  logic [AW-1:0]      fw_addr,
    input  logic [FIELD_W-1:0] fw_data,
    input  logic               h_valid,
    output logic               h_ready,
    input  logic [AW-1:0]      h_addr,
    input  logic [WIDTH-1:0]   h_data,
    input  logic               clr_start,
    output logic               busy,
    output logic               clr_done,
    output logic               fw_drop,
    output logic               par_err
);

`ifdef CSRAM_PARITY_EN
    localparam int SW = WIDTH + 2;  // [WIDTH] field parity, [WIDTH+1] rest parity
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [WIDTH-1:0] FMASK   = WIDTH'(field_mask(FIELD_LSB, FIELD_W));
    localparam logic [AW:0]      DEPTH_L = (AW+1)'(NUM_NEURONS);
    localparam logic [AW-1:0]    LAST    = AW'(NUM_NEURONS - 1);

    state_e             r_state;
    state_e             w_next;
    logic [AW-1:0]      r_cnt;
    logic               r_auto_pend;
    logic               r_fw_drop;
    logic               r_rd_valid;
    logic               r_rd_oob;
    logic               w_busy;
    logic               w_clr_done;
    logic               w_fw_ok;
    logic               w_h_ok;
    logic               w_rd_ok;
    src_e               w_src;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [SW-1:0]      w_wdata;
    logic [SW-1:0]      w_wmask;
    logic [FIELD_W-1:0] w_field_val;
    logic [WIDTH-1:0]   w_field_row;
    logic [SW-1:0]      w_rq;

    assign w_fw_ok = ({1'b0, fw_addr} < DEPTH_L);
    assign w_h_ok  = ({1'b0, h_addr}  < DEPTH_L);
    assign w_rd_ok = ({1'b0, rd_addr} < DEPTH_L);

    // NOTE: combinational processes use blocking assignments and give every
    // output a default first, so no path through them can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_busy     = 1'b0;
        w_clr_done = 1'b0;
        unique case (r_state)
            IDLE:  if (clr_start || r_auto_pend) w_next = CLEAR;
            CLEAR: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                w_clr_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_auto_pend <= (AUTO_CLEAR != 0);
        end else begin
            r_state     <= w_next;
            r_auto_pend <= 1'b0;
            if (r_state == CLEAR) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign h_ready = !w_busy && !fw_en;

    always_comb begin
        w_src = SRC_NONE;
        if (w_busy)                            w_src = SRC_CLR;
        else if (fw_en && w_fw_ok)             w_src = SRC_FW;
        else if (h_valid && h_ready && w_h_ok) w_src = SRC_HOST;
    end

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = fw_addr;
        w_wdata     = '0;
        w_wmask     = '0;
        w_field_val = w_busy ? CLR_VALUE : fw_data;
        w_field_row = '0;
        w_field_row[FIELD_LSB +: FIELD_W] = w_field_val;
        unique case (w_src)
            SRC_CLR, SRC_FW: begin
                w_we    = 1'b1;
                w_waddr = (w_src == SRC_CLR) ? r_cnt : fw_addr;
`ifdef CSRAM_PARITY_EN
                w_wdata = {1'b0, ^w_field_val, w_field_row};
                w_wmask = {1'b0, 1'b1, FMASK};
`else
                w_wdata = w_field_row;
                w_wmask = FMASK;
`endif
            end
            SRC_HOST: begin
                w_we    = 1'b1;
                w_waddr = h_addr;
`ifdef CSRAM_PARITY_EN
                w_wdata = {^(h_data & ~FMASK), ^(h_data & FMASK), h_data};
`else
                w_wdata = h_data;
`endif
                w_wmask = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fw_drop  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            if (fw_en && w_busy) r_fw_drop <= 1'b1;
            else if (clr_start)  r_fw_drop <= 1'b0;
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_oob <= !w_rd_ok;
        end
    end

    csram_sdp_array #(
        .DEPTH (NUM_NEURONS),
        .AW    (AW),
        .DW    (SW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_wmask (w_wmask),
        .i_re    (rd_en && w_rd_ok),
        .i_raddr (rd_addr),
        .o_rdata (w_rq)
    );

    assign rd_data  = r_rd_oob ? '0 : w_rq[WIDTH-1:0];
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;
    assign clr_done = w_clr_done;
    assign fw_drop  = r_fw_drop;

`ifdef CSRAM_PARITY_EN
    assign par_err = r_rd_valid && !r_rd_oob &&
                     (((^(w_rq[WIDTH-1:0] & FMASK))  != w_rq[WIDTH]) ||
                      ((^(w_rq[WIDTH-1:0] & ~FMASK)) != w_rq[WIDTH+1]));
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_csram_ctrl.sv
// Scoreboard bench for csram_ctrl: reads push expected rows taken from an
// array model; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_csram_ctrl;

    localparam int N  = 256;
    localparam int W  = 368;
    localparam int FL = 103;
    localparam int FW = 9;
    localparam int AW = 8;
    localparam logic [W-1:0] FMASK = {{(W-FL-FW){1'b0}}, {FW{1'b1}}, {FL{1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          fw_en;
    logic [AW-1:0] fw_addr;
    logic [FW-1:0] fw_data;
    logic          h_valid;
    logic          h_ready;
    logic [AW-1:0] h_addr;
    logic [W-1:0]  h_data;
    logic          clr_start;
    logic          busy;
    logic          clr_done;
    logic          fw_drop;
    logic          par_err;

    csram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .fw_en     (fw_en),
        .fw_addr   (fw_addr),
        .fw_data   (fw_data),
        .h_valid   (h_valid),
        .h_ready   (h_ready),
        .h_addr    (h_addr),
        .h_data    (h_data),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .fw_drop   (fw_drop),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [W-1:0] data;
        logic [W-1:0] mask;
        logic        perr;
        bit          chk_perr;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] model [N];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not as required", name);
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    // Monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (sbq.size() == 0) fail_now("rd_valid_unexpected");
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check_int("rd_latency", cyc, e.due);
                    check_row("rd_data", rd_data & e.mask, e.data & e.mask);
                    if (e.chk_perr) check_bit("par_err", par_err, e.perr);
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                fail_now("rd_valid_missing");
                void'(sbq.pop_front());
            end
        end
    end

    // All stimulus tasks are entered and left at a negedge.
    task automatic issue_read(input int a, input logic [W-1:0] mask, input logic perr, input bit chk);
        exp_t e;
        rd_en      = 1'b1;
        rd_addr    = a[AW-1:0];
        e.due      = cyc + 1;
        e.data     = model[a];
        e.mask     = mask;
        e.perr     = perr;
        e.chk_perr = chk;
        sbq.push_back(e);
    endtask

    task automatic read_row(input int a);
        issue_read(a, '1, 1'b0, 1'b1);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic host_write(input int a, input logic [W-1:0] d);
        int t;
        t       = 0;
        h_valid = 1'b1;
        h_addr  = a[AW-1:0];
        h_data  = d;
        #1;
        while (!h_ready && t < 16) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!h_ready) fail_now("host_accept_timeout");
        else model[a] = d;
        @(negedge clk);
        h_valid = 1'b0;
    endtask

    task automatic clear_model_fields();
        for (int i = 0; i < N; i++) model[i][FL +: FW] = '0;
    endtask

    task automatic run_sweep(input int fw_at, input int fw_row, input logic [FW-1:0] fw_val,
                             input int rst_at, output int nbusy, output int ndone);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int it = 0; it < 700; it++) begin
            fw_en = 1'b0;
            if (busy) nbusy++;
            if (clr_done) begin
                ndone++;
                seen = 1'b1;
            end else if (seen) break;
            if (busy && nbusy == 5) begin
                #1;
                check_bit("h_ready_while_busy", h_ready, 1'b0);
            end
            if (busy && nbusy == fw_at) begin
                fw_en   = 1'b1;
                fw_addr = fw_row[AW-1:0];
                fw_data = fw_val;
            end
            if (busy && nbusy == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_bit("busy_on_reset", busy, 1'b0);
                check_bit("rd_valid_on_reset", rd_valid, 1'b0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("sweep_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           nb;
        int           nd;
        bit           h_pend;
        logic [W-1:0] d;

        for (int i = 0; i < N; i++) model[i] = '0;
        rst_n = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        fw_en = 1'b0; fw_addr = '0; fw_data = '0;
        h_valid = 1'b0; h_addr = '0; h_data = '0;
        clr_start = 1'b0;
        repeat (3) @(negedge clk);

        check_row("reset_rd_data", rd_data, '0);
        check_bit("reset_rd_valid", rd_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_clr_done", clr_done, 1'b0);
        check_bit("reset_fw_drop", fw_drop, 1'b0);
        check_bit("reset_par_err", par_err, 1'b0);

        // Automatic sweep after reset release; only the field is known afterwards.
        rst_n = 1'b1;
        run_sweep(-1, 0, '0, -1, nb, nd);
        check_int("auto_sweep_busy_cycles", nb, N);
        check_int("auto_sweep_done_pulses", nd, 1);
        issue_read(255, FMASK, 1'b0, 1'b0);
        @(negedge clk);
        issue_read(0, FMASK, 1'b0, 1'b0);
        @(negedge clk);
        rd_en = 1'b0;

        for (int i = 0; i < N; i++) host_write(i, rand_row());

        // Commanded sweep with a dropped write-back to an already-cleared row.
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        run_sweep(10, 2, 9'h1FF, -1, nb, nd);
        check_int("cmd_sweep_busy_cycles", nb, N);
        check_int("cmd_sweep_done_pulses", nd, 1);
        check_bit("fw_drop_set", fw_drop, 1'b1);
        clear_model_fields();
        read_row(255);
        read_row(2);

        // Host write while idle, then a field write-back on top of it.
        h_valid = 1'b1; h_addr = 8'd5; h_data = '1;
        #1;
        check_bit("h_ready_idle", h_ready, 1'b1);
        model[5] = '1;
        @(negedge clk);
        h_valid = 1'b0;
        read_row(5);
        fw_en = 1'b1; fw_addr = 8'd5; fw_data = 9'h0A5;
        model[5][FL +: FW] = 9'h0A5;
        @(negedge clk);
        fw_en = 1'b0;
        read_row(5);

        // Same-cycle field write, host write and read on row 7.
        d = rand_row();
        fw_en = 1'b1; fw_addr = 8'd7; fw_data = 9'h13C;
        h_valid = 1'b1; h_addr = 8'd7; h_data = d;
        issue_read(7, '1, 1'b0, 1'b1);
        #1;
        check_bit("h_ready_fw_priority", h_ready, 1'b0);
        model[7][FL +: FW] = 9'h13C;
        @(negedge clk);
        fw_en = 1'b0;
        issue_read(7, '1, 1'b0, 1'b1);
        #1;
        check_bit("h_ready_after_fw", h_ready, 1'b1);
        model[7] = d;
        @(negedge clk);
        h_valid = 1'b0;
        read_row(7);

        // Random traffic while idle.
        h_pend = 1'b0;
        for (int it = 0; it < 300; it++) begin
            rd_en = 1'b0;
            if ($urandom_range(1, 0) == 1) issue_read($urandom_range(N-1, 0), '1, 1'b0, 1'b1);
            fw_en   = ($urandom_range(3, 0) == 0);
            fw_addr = 8'($urandom_range(N-1, 0));
            fw_data = 9'($urandom);
            if (!h_pend && $urandom_range(2, 0) == 0) begin
                h_pend = 1'b1;
                h_addr = 8'($urandom_range(N-1, 0));
                h_data = rand_row();
            end
            h_valid = h_pend;
            #1;
            if (h_valid) check_bit("h_ready_random", h_ready, !fw_en);
            if (fw_en) model[fw_addr][FL +: FW] = fw_data;
            else if (h_valid) begin
                model[h_addr] = h_data;
                h_pend = 1'b0;
            end
            @(negedge clk);
        end
        rd_en = 1'b0; fw_en = 1'b0; h_valid = 1'b0;
        @(negedge clk);

`ifdef CSRAM_PARITY_EN
        dut.u_array.r_mem[3][0] = ~dut.u_array.r_mem[3][0];
        model[3][0] = ~model[3][0];
        issue_read(3, '1, 1'b1, 1'b1);
        @(negedge clk);
        issue_read(4, '1, 1'b0, 1'b1);
        @(negedge clk);
        rd_en = 1'b0;
        host_write(3, rand_row());
`endif

        // clr_start clears fw_drop; reset at sweep cycle 100 restarts from row 0.
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        check_bit("fw_drop_cleared", fw_drop, 1'b0);
        run_sweep(-1, 0, '0, 100, nb, nd);
        check_int("reset_at_sweep_cycle", nb, 100);
        run_sweep(-1, 0, '0, -1, nb, nd);
        check_int("restart_sweep_busy_cycles", nb, N);
        check_int("restart_sweep_done_pulses", nd, 1);
        check_bit("fw_drop_after_reset", fw_drop, 1'b0);
        clear_model_fields();
        read_row(0);
        read_row(100);
        read_row(255);
        read_row(7);

        repeat (4) @(negedge clk);
        check_int("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
